serial_adder_sub: RTL and testbench

//  Parametrised bit-serial adder/subtractor: one full-adder cell plus carry flip-flop

---
 rtl/serial_adder_sub.sv | 117 +++++++++++
 tb/tb_serial_adder_sub.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_sub.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flip-flop process
// a WIDTH-bit operand pair LSB-first, one bit per clock, with a start/done handshake.
module serial_adder_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [7:0]       minterm;
    logic             fa_s, fa_c;
    logic [WIDTH-1:0] res_next;

    // Full-adder cell built from a one-hot decode of {a, b, carry}.
    always_comb begin
        minterm  = 8'd1 << {a_sh_q[0], b_sh_q[0], carry_q};
        fa_s     = minterm[1] | minterm[2] | minterm[4] | minterm[7];
        fa_c     = minterm[3] | minterm[5] | minterm[6] | minterm[7];
        res_next = {fa_s, res_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtraction is a + ~b + ~cin, so cout reads as "no borrow".
                    a_sh_d  = a;
                    b_sh_d  = mode ? ~b : b;
                    carry_d = mode ? ~cin : cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = res_next;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = fa_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // carry_q here is the carry into the MSB.
                    sum_d   = res_next;
                    cout_d  = fa_c;
                    ovf_d   = fa_c ^ carry_q;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_sub.sv
// Self-checking bench for serial_adder_sub: directed 8-bit cases plus an exhaustive
// 4-bit sweep, with expected results queued at start and compared on each done pulse.
module tb_serial_adder_sub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, mode8, cin8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    logic       start4, mode4, cin4, busy4, done4, cout4, ovf4;
    logic [3:0] a4, b4, sum4;

    int total = 0;
    int bad   = 0;
    int q8[$];
    int q4[$];
    int dones8 = 0;
    int dones4 = 0;

    serial_adder_sub #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_adder_sub #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .mode(mode4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference result packed as {ovf, cout, sum}.
    function automatic int model(input int w, input int av, input int bv, input int ci, input int m);
        int mask, r, co, sa, sb, v, ov;
        mask = (1 << w) - 1;
        if (m == 0) begin
            r  = av + bv + ci;
            co = (r >> w) & 1;
        end else begin
            r  = av - bv - ci;
            co = (av >= bv + ci) ? 1 : 0;
        end
        sa = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
        sb = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
        v  = (m == 0) ? sa + sb + ci : sa - sb - ci;
        ov = ((v > (1 << (w - 1)) - 1) || (v < -(1 << (w - 1)))) ? 1 : 0;
        return (ov << (w + 1)) | (co << w) | (r & mask);
    endfunction

    always @(negedge clk) begin
        if (done8) begin
            dones8++;
            if (q8.size() == 0) chk("spurious_done8", 1, 0);
            else                chk("res8", {ovf8, cout8, sum8}, q8.pop_front());
        end
        if (done4) begin
            dones4++;
            if (q4.size() == 0) chk("spurious_done4", 1, 0);
            else                chk("res4", {ovf4, cout4, sum4}, q4.pop_front());
        end
    end

    task automatic op8(input int m, input int av, input int bv, input int ci);
        mode8  = m[0];
        a8     = av[7:0];
        b8     = bv[7:0];
        cin8   = ci[0];
        start8 = 1'b1;
        q8.push_back(model(8, av, bv, ci, m));
        @(posedge clk);
        #1 start8 = 1'b0;
    endtask

    task automatic idle8();
        repeat (9) @(posedge clk);
        #1;
    endtask

    task automatic op4(input int m, input int av, input int bv, input int ci);
        mode4  = m[0];
        a4     = av[3:0];
        b4     = bv[3:0];
        cin4   = ci[0];
        start4 = 1'b1;
        q4.push_back(model(4, av, bv, ci, m));
        @(posedge clk);
        #1 start4 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first;
        int d0;
        rst = 1'b1;
        start8 = 1'b0; mode8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; mode4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_sum",  sum8,  0);
        chk("rst_cout", cout8, 0);
        chk("rst_ovf",  ovf8,  0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // First op: latency and handshake timing.
        op8(0, 'h5A, 'h3C, 0);
        chk("busy_run", busy8, 1);
        first = 0;
        for (int n = 1; n <= 9; n++) begin
            @(posedge clk);
            #1;
            if (done8 && first == 0) first = n;
        end
        chk("done_lat", first + 1, 9);
        chk("done_pulse", done8, 0);
        chk("busy_idle", busy8, 0);

        op8(0, 'hFF, 'h01, 0); idle8();
        op8(0, 'hFF, 'h00, 1); idle8();
        op8(1, 'h10, 'h01, 0); idle8();
        op8(1, 'h80, 'h01, 0); idle8();
        op8(1, 'h00, 'h01, 0); idle8();
        repeat (5) @(posedge clk);
        #1;
        chk("sum_hold", sum8, 'hFF);
        for (int i = 0; i < 6; i++) begin
            op8($urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
            idle8();
        end

        // Start while busy must be ignored.
        d0 = dones8;
        op8(0, 'h12, 'h34, 0);
        repeat (3) @(posedge clk);
        #1;
        start8 = 1'b1; a8 = 'hFF; b8 = 'hFF; mode8 = 1'b1; cin8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("single_done", dones8 - d0, 1);
        chk("ignored_sum", sum8, 'h46);

        // Reset mid-run at cnt=4.
        op8(0, 'h21, 'h43, 1); idle8();
        op8(1, 'h55, 'h22, 0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        q8.delete();
        @(posedge clk);
        #1;
        chk("mid_rst_busy", busy8, 0);
        chk("mid_rst_done", done8, 0);
        chk("mid_rst_sum",  sum8,  0);
        chk("mid_rst_cout", cout8, 0);
        chk("mid_rst_ovf",  ovf8,  0);
        rst = 1'b0;
        d0 = dones8;
        repeat (12) @(posedge clk);
        #1;
        chk("no_done_after_rst", dones8 - d0, 0);
        op8(0, 'h0F, 'h01, 0); idle8();
        chk("post_rst_sum", sum8, 'h10);

        // Exhaustive 4-bit sweep at minimum spacing.
        for (int m = 0; m < 2; m++)
            for (int av = 0; av < 16; av++)
                for (int bv = 0; bv < 16; bv++)
                    for (int ci = 0; ci < 2; ci++)
                        op4(m, av, bv, ci);
        repeat (3) @(posedge clk);
        #1;
        chk("dones4", dones4, 1024);
        chk("pending8", q8.size(), 0);
        chk("pending4", q4.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
